// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions.
// Holds the default geometry and the tag/count types used by the ROB pointer controller,
// the ROB payload storage and the rename/issue logic.
package rob_pkg;

    localparam int unsigned ROB_DEPTH    = 16;
    localparam int unsigned ROB_WIDTH    = 4;
    localparam int unsigned ROB_WB_PORTS = 2;
    localparam int unsigned ROB_IDX_W    = $clog2(ROB_DEPTH);

    // Entry tag / storage index.
    typedef logic [ROB_IDX_W-1:0] rob_tag_t;
    // Occupancy; one extra bit so that "full" is distinguishable from "empty".
    typedef logic [ROB_IDX_W:0]   rob_cnt_t;

endpackage

// File: rtl/rob_ctrl_if.sv
// Reorder-buffer control interface.
// Groups the dispatch, writeback, commit, flush and status signals of rob_ctrl.
//   master : the pipeline side (drives requests, observes tags and status)
//   slave  : rob_ctrl itself
// Multi-lane tag buses are packed with lane 0 in the least significant IDX_W bits.
interface rob_ctrl_if
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH    = ROB_DEPTH,
    parameter int unsigned WIDTH    = ROB_WIDTH,
    parameter int unsigned WB_PORTS = ROB_WB_PORTS
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    // Dispatch
    logic [WIDTH-1:0]          disp_valid;
    logic                      disp_ready;
    logic [WIDTH*IDX_W-1:0]    disp_tag;
    // Writeback
    logic [WB_PORTS-1:0]       wb_valid;
    logic [WB_PORTS*IDX_W-1:0] wb_tag;
    // Commit
    logic                      commit_stall;
    logic [WIDTH-1:0]          commit_valid;
    logic [WIDTH*IDX_W-1:0]    commit_tag;
    // Control / status
    logic                      flush;
    logic [IDX_W:0]            count;
    logic                      full;
    logic                      empty;

    modport master (
        output disp_valid, wb_valid, wb_tag, commit_stall, flush,
        input  disp_ready, disp_tag, commit_valid, commit_tag, count, full, empty
    );

    modport slave (
        input  disp_valid, wb_valid, wb_tag, commit_stall, flush,
        output disp_ready, disp_tag, commit_valid, commit_tag, count, full, empty
    );

endinterface

// File: rtl/rob_commit_sel.sv
// Commit lane selector for the reorder buffer.
// Walks WIDTH lanes starting at the head and grants retirement to the longest run of
// entries that are both valid and done (prefix-AND scan), bounded by the occupancy.
//   head_i         : tag of the oldest entry
//   count_i        : registered occupancy
//   valid_i/done_i : per-entry state
//   commit_stall_i : blocks all retirement this cycle
//   commit_valid_o : per-lane grant, contiguous from lane 0
//   commit_cnt_o   : number of granted lanes
module rob_commit_sel #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 4,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic [IDX_W-1:0] head_i,
    input  logic [IDX_W:0]   count_i,
    input  logic [DEPTH-1:0] valid_i,
    input  logic [DEPTH-1:0] done_i,
    input  logic             commit_stall_i,
    output logic [WIDTH-1:0] commit_valid_o,
    output logic [IDX_W:0]   commit_cnt_o
);
    typedef logic [IDX_W-1:0] tag_t;
    typedef logic [IDX_W:0]   cnt_t;

    logic run;
    tag_t lane_tag;

    always_comb begin
        run            = !commit_stall_i;
        lane_tag       = head_i;
        commit_valid_o = '0;
        commit_cnt_o   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            lane_tag = head_i + tag_t'(i);
            // Once one lane fails, every younger lane is blocked.
            run = run && (count_i > cnt_t'(i)) && valid_i[lane_tag] && done_i[lane_tag];
            commit_valid_o[i] = run;
            commit_cnt_o      = commit_cnt_o + cnt_t'(run);
        end
    end

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer pointer and state controller.
// Allocates up to WIDTH in-order entries per cycle, records out-of-order completions from
// WB_PORTS writeback ports and retires up to WIDTH contiguous completed entries from the head.
// Payload storage is external; disp_tag/commit_tag are the write/read indices it uses.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus          : rob_ctrl_if slave (dispatch, writeback, commit, flush, status)
module rob_ctrl
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH    = ROB_DEPTH,
    parameter int unsigned WIDTH    = ROB_WIDTH,
    parameter int unsigned WB_PORTS = ROB_WB_PORTS,
    localparam int unsigned IDX_W   = $clog2(DEPTH)
) (
    input logic       clk,
    input logic       reset_n,
    rob_ctrl_if.slave bus
);
    typedef logic [IDX_W-1:0] tag_t;
    typedef logic [IDX_W:0]   cnt_t;

    localparam cnt_t DepthC = cnt_t'(DEPTH);

    tag_t             head_q, head_d;
    tag_t             tail_q, tail_d;
    cnt_t             count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q, done_d;

    cnt_t             disp_n;
    logic             disp_ready;
    logic             disp_fire;
    logic [WIDTH-1:0] commit_valid;
    cnt_t             commit_n;
    tag_t             wb_tag_p;

    // Dispatch: all-or-nothing against the registered occupancy, so a same-cycle
    // commit never makes room for this cycle's group.
    always_comb begin
        disp_n = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            disp_n = disp_n + cnt_t'(bus.disp_valid[i]);
        end
    end

    assign disp_ready = (DepthC - count_q) >= disp_n;
    assign disp_fire  = disp_ready && (disp_n != '0);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane_tag
        assign bus.disp_tag[i*IDX_W +: IDX_W]   = tail_q + tag_t'(i);
        assign bus.commit_tag[i*IDX_W +: IDX_W] = head_q + tag_t'(i);
    end

    rob_commit_sel #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_commit_sel (
        .head_i         (head_q),
        .count_i        (count_q),
        .valid_i        (valid_q),
        .done_i         (done_q),
        .commit_stall_i (bus.commit_stall),
        .commit_valid_o (commit_valid),
        .commit_cnt_o   (commit_n)
    );

    assign bus.commit_valid = commit_valid;
    assign bus.disp_ready   = disp_ready;
    assign bus.count        = count_q;
    assign bus.full         = (count_q == DepthC);
    assign bus.empty        = (count_q == '0);

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        valid_d  = valid_q;
        done_d   = done_q;
        wb_tag_p = '0;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
            done_d  = '0;
        end else begin
            // Completions only land on live entries; duplicates simply set the bit twice.
            for (int unsigned p = 0; p < WB_PORTS; p++) begin
                wb_tag_p = bus.wb_tag[p*IDX_W +: IDX_W];
                if (bus.wb_valid[p] && valid_q[wb_tag_p]) begin
                    done_d[wb_tag_p] = 1'b1;
                end
            end
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (commit_valid[i]) begin
                    valid_d[head_q + tag_t'(i)] = 1'b0;
                    done_d[head_q + tag_t'(i)]  = 1'b0;
                end
            end
            // Dispatch targets only free entries, so it never collides with the above.
            if (disp_fire) begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (bus.disp_valid[i]) begin
                        valid_d[tail_q + tag_t'(i)] = 1'b1;
                        done_d[tail_q + tag_t'(i)]  = 1'b0;
                    end
                end
            end
            head_d  = head_q + tag_t'(commit_n);
            tail_d  = tail_q + (disp_fire ? tag_t'(disp_n) : tag_t'(0));
            count_d = count_q + (disp_fire ? disp_n : cnt_t'(0)) - commit_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: doc/rob_ctrl.md
Name: rob_ctrl

Overview:
- Pointer and state controller for the 4-way reorder buffer storage array.
- Allocates up to WIDTH in-order entries per cycle at dispatch and records out-of-order completions from writeback ports.
- Retires up to WIDTH contiguous completed entries per cycle from the head and clears all state on flush.
- Payload storage is external; this block supplies the tags/indices the storage uses for writes and reads.

Parameters:
- DEPTH, 16, number of ROB entries; must be a power of 2 and at least WIDTH.
- WIDTH, 4, dispatch and commit lanes per cycle.
- WB_PORTS, 2, number of writeback completion ports.
- IDX_W, $clog2(DEPTH), tag width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- disp_valid  in  WIDTH  per-lane dispatch request; must be contiguous from lane 0.
- disp_ready  out  1  dispatch group accepted this cycle.
- disp_tag  out  WIDTH*IDX_W  lane i tag = (tail+i) mod DEPTH.
- wb_valid  in  WB_PORTS  completion strobe per port.
- wb_tag  in  WB_PORTS*IDX_W  tag of the completing entry.
- commit_stall  in  1  suppresses all retirement this cycle.
- commit_valid  out  WIDTH  per-lane retirement, contiguous from lane 0.
- commit_tag  out  WIDTH*IDX_W  lane i tag = (head+i) mod DEPTH.
- flush  in  1  discard all entries.
- count  out  IDX_W+1  occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (async, reset_n=0):
  - head=0, tail=0, count=0; valid[] and done[] all cleared.
  - Outputs: empty=1, full=0, commit_valid=0, disp_ready=1.
  - disp_tag = {3,2,1,0}, commit_tag = {3,2,1,0}.
  - If reset is asserted mid-operation, all in-flight state is dropped immediately.
- Dispatch:
  - n = popcount(disp_valid).
  - disp_ready = (DEPTH - count_reg) >= n, computed combinationally. Acceptance is all-or-nothing.
  - On accept with n>0: set valid=1 and done=0 for tags tail..tail+n-1; tail += n mod DEPTH.
  - disp_valid=0: disp_ready=1 and no state change.
  - Non-contiguous disp_valid is illegal; the bench asserts on it.
- Writeback:
  - wb_valid[p] with valid[wb_tag[p]]=1 sets done next cycle.
  - Writeback to an invalid entry is ignored.
  - Duplicate tags on multiple ports in the same cycle are idempotent.
- Commit (combinational from registered state):
  - commit_valid[i]=1 iff commit_stall=0, count_reg>i, and valid&done hold for every tag head..head+i.
  - On the clock edge, clear valid and done for the k committed entries; head += k.
  - A writeback-to-commit path takes at least 1 cycle; done is never bypassed into commit.
- count_next = count + n_accepted - k_committed.
  - A commit in the same cycle does NOT free space for that cycle's dispatch; disp_ready uses count_reg.
- Wrap-around: all pointer and tag arithmetic is mod DEPTH (IDX_W-bit natural wrap). count disambiguates full from empty.
- Flush (synchronous, highest priority):
  - head=tail=count=0; valid[] and done[] cleared.
  - Same-cycle dispatch, writeback and commit state updates are discarded.
  - disp_ready and commit_valid outputs remain combinational; the consumer must ignore them during flush.
- No internal FSM beyond the pointers; every output except disp_ready/commit_* is a function of registered state.

Decomposition:
- Shared package rob_pkg:
  - localparams ROB_DEPTH, ROB_WIDTH, ROB_IDX_W.
  - typedef rob_tag_t = logic [ROB_IDX_W-1:0].
  - typedef rob_cnt_t = logic [ROB_IDX_W:0].
  - Reused by the ROB storage FIFO and the rename/issue logic.
- One sub-module, rob_commit_sel:
  - Inputs: head, count, valid[], done[], commit_stall.
  - Outputs: commit_valid and k, via a prefix-AND scan over WIDTH lanes.
- Dispatch popcount and tag generation stay inline.

Test Plan:
- Reset, then idle -> empty=1, full=0, count=0, disp_ready=1, disp_tag={3,2,1,0}, commit_valid=0.
- disp_valid=4'hF for 4 cycles -> count=16, full=1, tail=0. Then disp_valid=4'b0001 -> disp_ready=0 and count stays 16.
- After 4 dispatches (tags 0-3), wb tags 2 and 0 in one cycle -> next cycle commit_valid=4'b0001 (tag 0). Then wb tag 1 -> next cycle commit_valid=4'b0011 with tags 1,2.
- Wrap: with head=tail=14 and count=0, dispatch 4'hF -> disp_tag={1,0,15,14}, tail=2; complete all four -> commit tags 14,15,0,1, head=2.
- Full, tags at head done, disp_valid=4'b0011 -> disp_ready=0, two commits, count=14. Next cycle disp_ready=1 and count=16.
- Mid-operation, count=9: assert flush with wb_valid=1 and disp_valid=4'hF -> next cycle count=0, empty=1, head=tail=0, commit_valid=0; the earlier wb tag stays not-done after re-dispatch.
- commit_stall=1 with 4 done entries -> commit_valid=0 and count unchanged. Deassert -> commit_valid=4'hF.
